mips_data_responder: RTL
========================

# mips_data_responder

Memory-side responder for the pipelined MIPS CPU's data port. It serves the CPU's combinational X-stage requests (address, big-endian byte write enables, read enable, write data) and returns read data registered for the M stage, one cycle later. It implements a word RAM plus a small MMIO page: cycle counter, LED register, status, and a console byte FIFO drained over a valid/ready port. When the console FIFO is full, it stalls the CPU through `cpu_en`.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words (power of 2); `AW = log2(RAM_WORDS)`.
- `FIFO_DEPTH`, 4: console FIFO entries (power of 2, at least 2).
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: global run enable from the system.
- `cpu_en` out 1: enable driven to the CPU's `en`; equals `en & ~stall`.
- `mem_addr` in 32: byte address from the CPU X stage.
- `mem_write_en` in 4: byte lane enables. Bit 3 = byte offset 0 = `[31:24]`; bit 0 = offset 3 = `[7:0]`.
- `mem_read_en` in 1: read request.
- `mem_write_data` in 32: write data; byte stores arrive replicated in all lanes.
- `mem_read_data` out 32: registered read data consumed by the CPU M stage.
- `tx_valid` out 1: console FIFO head valid.
- `tx_data` out 8: console FIFO head byte.
- `tx_ready` in 1: consumer accepts head.
- `leds` out 8: LED register.

## Operation
- Decode uses `mem_addr[31:16]`:
  - `16'hFFFF` selects MMIO.
  - Any other value selects RAM, word index `mem_addr[AW+1:2]`; higher bits are ignored, so the RAM aliases/wraps.
- MMIO map (offset `mem_addr[15:0] & ~3`):
  - 0x0 CYCLES: RO, 32-bit.
  - 0x4 LEDS: RW, value in `[7:0]`, written only if `mem_write_en[0]`.
  - 0x8 CONSOLE: WO; any nonzero `mem_write_en` pushes `mem_write_data[7:0]`.
  - 0xC STATUS: RO, `{27'b0, count[2:0]... }` laid out as bit0 full, bit1 empty, bits[4:2] count (saturating display of the occupancy), rest 0.
  - Unmapped offsets read 0; writes to them are ignored.
- RAM write: each lane is written iff its enable is set and `cpu_en` is high.
- Read: on a clock edge with `mem_read_en & cpu_en`, `mem_read_data` is loaded with the selected word. Otherwise it holds, so the CPU M stage sees stable data during stalls.
- A simultaneous read and write to the same word returns the old data. The CPU issues one access per cycle, so this case is defined but unused.
- Stall: `stall = (CONSOLE write) & fifo_full`.
  - While stalled, no state update from the CPU request occurs: no push, no RAM/LED write, no read capture.
  - The CPU holds its request, and the access completes on the first cycle `stall` is low.
- FIFO:
  - Pop on `tx_valid & tx_ready`, independent of `en`.
  - Push and pop in the same cycle when not full: both occur and the count is unchanged.
  - Pop while stalled frees a slot; the push occurs the next cycle.
- CYCLES increments every clock with `en` high, wraps at 2^32, and is not gated by `stall`.

## Timing
- Read latency: exactly 1 cycle. Data is captured at the edge ending the request cycle and is valid for the whole following cycle.
- `cpu_en` is combinational from `en`, `mem_addr`, `mem_write_en` and FIFO state. It has no path from `tx_ready`.
- `tx_valid`/`tx_data` are registered FIFO outputs. A byte pushed at edge N is visible after edge N; the earliest pop is at edge N+1.
- Reset (`rst_n` low, asynchronous) clears:
  - `mem_read_data` = 0, `leds` = 0, CYCLES = 0.
  - FIFO empty, `tx_valid` = 0, `tx_data` = 0.
  - `cpu_en` follows `en`.
- RAM contents are not reset.
- Reset mid-stall drops the pending push and empties the FIFO.

## Structure
- Package `mips_mem_map_pkg`: `MMIO_PAGE` = 16'hFFFF; offsets `OFF_CYCLES`, `OFF_LEDS`, `OFF_CONSOLE`, `OFF_STATUS`; STATUS bit positions.
- Sub-module `mem_tx_fifo`: parameterised width/depth, push/pop/full/empty/count, registered head output.
- The RAM is inferred inline as a byte-lane-writable array.

## Test plan
- sw 0x11223344 to 0x40, then lw 0x40 → `mem_read_data` = 0x11223344 one cycle after the read cycle.
- sb 0xAA to 0x41 (`mem_write_en` = 4'b0100, data 0xAAAAAAAA) over 0x11223344, then lw → 0x11AA3344.
- Write to 0x40 + 4·RAM_WORDS, then read 0x40 → aliases to the same word.
- sw 0x5A to 0xFFFF0004 → `leds` = 0x5A; lw 0xFFFF0004 → 0x0000005A; lw 0xFFFF0000 on two reads k cycles apart → values differ by k.
- Hold `tx_ready` = 0 and push 5 console bytes with FIFO_DEPTH = 4:
  - 5th write drives `cpu_en` = 0; STATUS reads 0x11 (full, count 4).
  - Raise `tx_ready` one cycle: pop byte 1; byte 5 is pushed next cycle with `cpu_en` = 1.
  - Drain order 1..5.
- Assert `rst_n` low mid-stall → `cpu_en` = `en`, `tx_valid` = 0, `leds` = 0, `mem_read_data` = 0 immediately (async).

Source files
------------

// File: rtl/mips_mem_map_pkg.sv
// Address map and STATUS layout shared by the MIPS data-port responder.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package mips_mem_map_pkg;

    localparam logic [15:0] MMIO_PAGE   = 16'hFFFF;

    localparam logic [15:0] OFF_CYCLES  = 16'h0000;
    localparam logic [15:0] OFF_LEDS    = 16'h0004;
    localparam logic [15:0] OFF_CONSOLE = 16'h0008;
    localparam logic [15:0] OFF_STATUS  = 16'h000C;

    // STATUS register layout
    localparam int          ST_FULL_BIT  = 0;
    localparam int          ST_EMPTY_BIT = 1;
    localparam int          ST_COUNT_LSB = 2;
    localparam int          ST_COUNT_W   = 3;
    localparam logic [31:0] ST_COUNT_MAX = 32'd7;

    // Occupancy is shown saturated so deeper FIFOs still fit the 3-bit field.
    function automatic logic [31:0] status_word(input logic        full,
                                                input logic        empty,
                                                input logic [31:0] count);
        logic [31:0]           w;
        logic [ST_COUNT_W-1:0] c;
        w = '0;
        c = (count > ST_COUNT_MAX) ? ST_COUNT_MAX[ST_COUNT_W-1:0]
                                   : count[ST_COUNT_W-1:0];
        w[ST_FULL_BIT]                   = full;
        w[ST_EMPTY_BIT]                  = empty;
        w[ST_COUNT_LSB +: ST_COUNT_W]    = c;
        return w;
    endfunction

endpackage

// File: rtl/mem_tx_fifo.sv
// Generic synchronous FIFO with push/pop, full/empty/count and a head output.
// Latency: a pushed entry is visible at the head after the push edge; pop takes effect at the next edge.
// Backpressure: push ignored while full, pop ignored while empty; caller gates push with full.
// Ports: clk/rst_n; push/push_dat write side; pop read side; full, empty, count status;
//        head_vld/head_dat present the oldest entry straight from storage flops.
module mem_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_vld,
    output logic [W-1:0]             head_dat
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                store[wr_ptr] <= push_dat;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign head_vld = ~empty;
    assign head_dat = store[rd_ptr];

endmodule

// File: rtl/mips_data_responder.sv
// Data-port responder for the pipelined MIPS CPU: word RAM plus MMIO page (cycles, LEDs, console, status).
// Latency: reads return one cycle after the request cycle; mem_read_data holds otherwise.
// Backpressure: a console write while the console FIFO is full drops cpu_en until a slot frees.
// Ports: en/cpu_en run enables; mem_* CPU request and registered read data;
//        tx_valid/tx_data/tx_ready console byte stream; leds LED register.
module mips_data_responder
    import mips_mem_map_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        cpu_en,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_write_en,
    input  logic        mem_read_en,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [7:0]  leds
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   cycles;
    logic          is_mmio;
    logic [15:0]   off;
    logic [AW-1:0] word_idx;
    logic          con_wr;
    logic          stall;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   rd_word;
    logic          unused_addr;

    assign is_mmio  = (mem_addr[31:16] == MMIO_PAGE);
    assign off      = {mem_addr[15:2], 2'b00};
    assign word_idx = mem_addr[AW+1:2];   // upper bits ignored: RAM aliases
    assign unused_addr = ^mem_addr[1:0];

    assign con_wr = is_mmio & (off == OFF_CONSOLE) & (|mem_write_en);
    assign stall  = con_wr & fifo_full;
    assign cpu_en = en & ~stall;

    // RAM: byte-lane writable, not reset. Lane b covers bits [8b+7:8b].
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!is_mmio && cpu_en && mem_write_en[b]) begin
                ram[word_idx][b*8 +: 8] <= mem_write_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (is_mmio) begin
            case (off)
                OFF_CYCLES: rd_word = cycles;
                OFF_LEDS:   rd_word = {24'b0, leds};
                OFF_STATUS: rd_word = status_word(fifo_full, fifo_empty, 32'(fifo_count));
                default:    rd_word = '0;
            endcase
        end else begin
            rd_word = ram[word_idx];
        end
    end

    // Read capture and LED write both wait out a stall; cycles only follows en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_data <= '0;
            leds          <= '0;
            cycles        <= '0;
        end else begin
            if (mem_read_en && cpu_en) begin
                mem_read_data <= rd_word;
            end
            if (is_mmio && off == OFF_LEDS && mem_write_en[0] && cpu_en) begin
                leds <= mem_write_data[7:0];
            end
            if (en) begin
                cycles <= cycles + 32'd1;
            end
        end
    end

    mem_tx_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (con_wr & cpu_en),
        .push_dat (mem_write_data[7:0]),
        .pop      (tx_valid & tx_ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head_vld (tx_valid),
        .head_dat (tx_data)
    );

endmodule
